cdb_arbiter: RTL and testbench

- Round-robin arbiter for the shared Common Data Bus (CDB).
- Collects CDB_rts requests from N_UNITS functional units (adder, multiplier, load buffer, ...) and grants the bus to exactly one unit at a time through a one-hot CDB_xmit vector.
- Sequences each broadcast: hold, release, then a one-cycle gap so the unit's falling-edge cleanup completes before regrant.
- Sits between the functional units and the CDB tri-state bus.

---
 rtl/cdb_pkg.sv | 21 ++
 rtl/cdb_arbiter_if.sv | 31 +++
 rtl/rr_pick.sv | 37 +++
 rtl/cdb_arbiter.sv | 125 ++++++++++++
 tb/tb_cdb_arbiter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/cdb_pkg.sv
// Shared types and constants for the Common Data Bus arbiter.
//   state_e      : arbiter sequencing states (IDLE -> XMIT -> GAP -> IDLE)
//   UNIT_*       : conventional CDB_rts/CDB_xmit bit positions of the units
//   MAX_HOLD     : largest supported HOLD_CYCLES; sizes the hold counter
package cdb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XMIT = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int unsigned UNIT_ADDER = 0;
  localparam int unsigned UNIT_MULT  = 1;
  localparam int unsigned UNIT_LOAD  = 2;
  localparam int unsigned UNIT_STORE = 3;

  localparam int unsigned MAX_HOLD = 15;
  localparam int unsigned HOLD_W   = $clog2(MAX_HOLD + 1);

endpackage

// File: rtl/cdb_arbiter_if.sv
// CDB request/grant bundle between the functional units and the arbiter.
//   CDB_rts     : per-unit ready-to-send, held until that unit's xmit falls
//   CDB_write   : bus write strobe driven by the granted unit
//   CDB_xmit    : one-hot grant, enables the unit's tri-state drivers
//   grant_valid : any grant active
//   grant_id    : index of current / most recent grantee
//   error       : one-cycle protocol-violation pulse
// master = arbiter side, slave = functional-unit side.
interface cdb_arbiter_if #(
  parameter int unsigned N_UNITS = 4,
  parameter int unsigned ID_W    = $clog2(N_UNITS)
);

  logic [N_UNITS-1:0] CDB_rts;
  logic               CDB_write;
  logic [N_UNITS-1:0] CDB_xmit;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic               error;

  modport master (
    input  CDB_rts, CDB_write,
    output CDB_xmit, grant_valid, grant_id, error
  );

  modport slave (
    output CDB_rts, CDB_write,
    input  CDB_xmit, grant_valid, grant_id, error
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : highest-priority index this round
//   found_c : any request present
//   idx_c   : first requesting index at or above ptr_i, wrapping
// The request vector is doubled so the wrap is a plain upward scan: bits
// below ptr_i in the low copy are masked off, the lowest remaining set bit
// is isolated with x & -x, and its position is folded back modulo N_UNITS.
module rr_pick #(
  parameter int unsigned N_UNITS = 4,
  parameter int unsigned ID_W    = $clog2(N_UNITS)
) (
  input  logic [N_UNITS-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               found_c,
  output logic [ID_W-1:0]    idx_c
);

  localparam int unsigned DW = 2 * N_UNITS;

  logic [DW-1:0] dbl;
  logic [DW-1:0] masked;
  logic [DW-1:0] lowest;

  // Mask, isolate lowest set bit, encode one-hot position mod N_UNITS
  always_comb begin
    dbl     = {req_i, req_i};
    masked  = dbl & ~((DW'(1) << ptr_i) - DW'(1));
    lowest  = masked & (~masked + DW'(1));
    found_c = |req_i;
    idx_c   = '0;
    for (int i = 0; i < int'(DW); i++) begin
      if (lowest[i]) idx_c = idx_c | ID_W'(i % int'(N_UNITS));
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the shared Common Data Bus.
//   clock   : system clock, all state changes on posedge
//   reset_n : asynchronous active-low reset
//   bus     : cdb_arbiter_if master (rts/write in; xmit/valid/id/error out)
// Each grant holds CDB_xmit for HOLD_CYCLES, then a one-cycle GAP lets the
// unit clear its CDB_rts on the falling xmit before the next pick.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned N_UNITS     = 4,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned ID_W        = $clog2(N_UNITS)
) (
  input  logic          clock,
  input  logic          reset_n,
  cdb_arbiter_if.master bus
);

  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N_UNITS - 1);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [N_UNITS-1:0]  xmit_q, xmit_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic                gvalid_q, gvalid_d;
  logic                err_q, err_d;
  logic                first_q, first_d;
  logic                drop_q, drop_d;

  logic                pick_found;
  logic [ID_W-1:0]     pick_idx;

  rr_pick #(
    .N_UNITS (N_UNITS),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i   (bus.CDB_rts),
    .ptr_i   (ptr_q),
    .found_c (pick_found),
    .idx_c   (pick_idx)
  );

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      hold_q   <= '0;
      xmit_q   <= '0;
      gid_q    <= '0;
      gvalid_q <= 1'b0;
      err_q    <= 1'b0;
      first_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      xmit_q   <= xmit_d;
      gid_q    <= gid_d;
      gvalid_q <= gvalid_d;
      err_q    <= err_d;
      first_q  <= first_d;
      drop_q   <= drop_d;
    end
  end

  // Next-state and grant sequencing
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    xmit_d   = xmit_q;
    gid_d    = gid_q;
    gvalid_d = gvalid_q;
    err_d    = 1'b0;
    first_d  = 1'b0;
    drop_d   = drop_q;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          xmit_d   = N_UNITS'(1) << pick_idx;
          gid_d    = pick_idx;
          gvalid_d = 1'b1;
          hold_d   = HOLD_INIT;
          first_d  = 1'b1;
          drop_d   = 1'b0;
          state_d  = XMIT;
        end
      end
      XMIT: begin
        // A premature drop is flagged once per grant; the grant still runs
        if (!bus.CDB_rts[gid_q] && !drop_q) begin
          err_d  = 1'b1;
          drop_d = 1'b1;
        end
        if (first_q && !bus.CDB_write) err_d = 1'b1;
        if (hold_q != '0) begin
          hold_d = hold_q - HOLD_W'(1);
        end else begin
          xmit_d   = '0;
          gvalid_d = 1'b0;
          // Explicit wrap so non-power-of-two N_UNITS works
          ptr_d    = (gid_q == LAST_ID) ? '0 : gid_q + ID_W'(1);
          state_d  = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.CDB_xmit    = xmit_q;
  assign bus.grant_valid = gvalid_q;
  assign bus.grant_id    = gid_q;
  assign bus.error       = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  typedef struct {
    logic       rst;
    logic [3:0] rts;
    logic       wr;
    logic [3:0] xmit;
    logic       valid;
    logic [1:0] id;
    logic       err;
  } vec_t;

  logic clk;
  logic rst1_n;
  logic rst3_n;
  int   checks;
  int   errors;
  vec_t vecs[$];

  cdb_arbiter_if #(.N_UNITS(4)) if1 ();
  cdb_arbiter_if #(.N_UNITS(4)) if3 ();

  cdb_arbiter #(.N_UNITS(4), .HOLD_CYCLES(1)) dut1 (
    .clock   (clk),
    .reset_n (rst1_n),
    .bus     (if1)
  );

  cdb_arbiter #(.N_UNITS(4), .HOLD_CYCLES(3)) dut3 (
    .clock   (clk),
    .reset_n (rst3_n),
    .bus     (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rst, input logic [3:0] rts, input logic wr,
                     input logic [3:0] xmit, input logic valid, input logic [1:0] id,
                     input logic err);
    vec_t v;
    v.rst = rst; v.rts = rts; v.wr = wr; v.xmit = xmit;
    v.valid = valid; v.id = id; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic do_reset1();
    rst1_n = 1'b0;
    #2;
    rst1_n = 1'b1;
  endtask

  // Hold-3 unit: set rts, clock once, compare xmit/id/error
  task automatic step3(input string name, input logic [3:0] rts, input logic [3:0] xmit,
                       input logic [1:0] id, input logic err);
    if3.CDB_rts = rts;
    step();
    chk({name, " xmit"}, 32'(if3.CDB_xmit), 32'(xmit));
    chk({name, " valid"}, 32'(if3.grant_valid), 32'(xmit != 4'b0000));
    chk({name, " id"}, 32'(if3.grant_id), 32'(id));
    chk({name, " err"}, 32'(if3.error), 32'(err));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst1_n = 1'b0;
    rst3_n = 1'b0;
    if1.CDB_rts = '0;
    if1.CDB_write = 1'b1;
    if3.CDB_rts = '0;
    if3.CDB_write = 1'b1;

    // Single request, hold 1
    add(0, 4'b0001, 1, 4'b0001, 1, 2'd0, 0);
    add(0, 4'b0001, 1, 4'b0000, 0, 2'd0, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd0, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd0, 0);
    // Contention 1011 from pointer 0: grants 0,1,3 three cycles apart
    add(1, 4'b1011, 1, 4'b0001, 1, 2'd0, 0);
    add(0, 4'b1011, 1, 4'b0000, 0, 2'd0, 0);
    add(0, 4'b1010, 1, 4'b0000, 0, 2'd0, 0);
    add(0, 4'b1010, 1, 4'b0010, 1, 2'd1, 0);
    add(0, 4'b1010, 1, 4'b0000, 0, 2'd1, 0);
    add(0, 4'b1000, 1, 4'b0000, 0, 2'd1, 0);
    add(0, 4'b1000, 1, 4'b1000, 1, 2'd3, 0);
    add(0, 4'b1000, 1, 4'b0000, 0, 2'd3, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd3, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd3, 0);
    // Pointer wrapped to 0: 0011 must grant unit 0 before unit 1
    add(0, 4'b0011, 1, 4'b0001, 1, 2'd0, 0);
    add(0, 4'b0011, 1, 4'b0000, 0, 2'd0, 0);
    add(0, 4'b0010, 1, 4'b0000, 0, 2'd0, 0);
    add(0, 4'b0010, 1, 4'b0010, 1, 2'd1, 0);
    add(0, 4'b0010, 1, 4'b0000, 0, 2'd1, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd1, 0);
    // Fairness: all units held high for 20 cycles
    add(1, 4'b1111, 1, 4'b0001, 1, 2'd0, 0);
    for (int u = 0; u < 6; u++) begin
      add(0, 4'b1111, 1, 4'b0000, 0, 2'(u % 4), 0);
      add(0, 4'b1111, 1, 4'b0000, 0, 2'(u % 4), 0);
      add(0, 4'b1111, 1, 4'(1 << ((u + 1) % 4)), 1, 2'((u + 1) % 4), 0);
    end
    add(0, 4'b1111, 1, 4'b0000, 0, 2'd2, 0);
    // Grantee not driving CDB_write at first XMIT edge
    add(1, 4'b0100, 0, 4'b0100, 1, 2'd2, 0);
    add(0, 4'b0100, 0, 4'b0000, 0, 2'd2, 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 2'd2, 0);

    step();
    chk("reset1 xmit", 32'(if1.CDB_xmit), 32'd0);
    chk("reset1 valid", 32'(if1.grant_valid), 32'd0);
    chk("reset1 id", 32'(if1.grant_id), 32'd0);
    chk("reset1 err", 32'(if1.error), 32'd0);
    chk("reset3 xmit", 32'(if3.CDB_xmit), 32'd0);
    rst1_n = 1'b1;
    rst3_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].rst) do_reset1();
      if1.CDB_rts = vecs[k].rts;
      if1.CDB_write = vecs[k].wr;
      step();
      chk($sformatf("vec%0d xmit", k), 32'(if1.CDB_xmit), 32'(vecs[k].xmit));
      chk($sformatf("vec%0d valid", k), 32'(if1.grant_valid), 32'(vecs[k].valid));
      chk($sformatf("vec%0d id", k), 32'(if1.grant_id), 32'(vecs[k].id));
      chk($sformatf("vec%0d err", k), 32'(if1.error), 32'(vecs[k].err));
      chk($sformatf("vec%0d onehot", k), 32'($onehot0(if1.CDB_xmit)), 32'd1);
    end
    if1.CDB_write = 1'b1;

    // Hold 3: unit 2 holds three cycles, unit 1 requesting meanwhile follows
    step3("h3 s1", 4'b0100, 4'b0100, 2'd2, 0);
    step3("h3 s2", 4'b0110, 4'b0100, 2'd2, 0);
    step3("h3 s3", 4'b0110, 4'b0100, 2'd2, 0);
    step3("h3 s4", 4'b0110, 4'b0000, 2'd2, 0);
    step3("h3 s5", 4'b0010, 4'b0000, 2'd2, 0);
    step3("h3 s6", 4'b0010, 4'b0010, 2'd1, 0);
    step3("h3 s7", 4'b0010, 4'b0010, 2'd1, 0);
    step3("h3 s8", 4'b0010, 4'b0010, 2'd1, 0);
    step3("h3 s9", 4'b0010, 4'b0000, 2'd1, 0);
    step3("h3 s10", 4'b0000, 4'b0000, 2'd1, 0);
    // Premature drop in second hold cycle: single error pulse, grant completes
    step3("drop s1", 4'b0001, 4'b0001, 2'd0, 0);
    step3("drop s2", 4'b0001, 4'b0001, 2'd0, 0);
    step3("drop s3", 4'b0000, 4'b0001, 2'd0, 1);
    step3("drop s4", 4'b0000, 4'b0000, 2'd0, 0);
    step3("drop s5", 4'b0000, 4'b0000, 2'd0, 0);

    // Async reset mid-XMIT, then pending unit 2 picked from pointer 0
    do_reset1();
    if1.CDB_rts = 4'b0001;
    step();
    chk("arst grant xmit", 32'(if1.CDB_xmit), 32'h1);
    #2;
    rst1_n = 1'b0;
    #1;
    chk("arst xmit", 32'(if1.CDB_xmit), 32'h0);
    chk("arst valid", 32'(if1.grant_valid), 32'h0);
    if1.CDB_rts = 4'b0100;
    #1;
    rst1_n = 1'b1;
    step();
    chk("arst regrant xmit", 32'(if1.CDB_xmit), 32'h4);
    chk("arst regrant id", 32'(if1.grant_id), 32'd2);
    chk("arst regrant err", 32'(if1.error), 32'd0);
    step();
    chk("arst exit xmit", 32'(if1.CDB_xmit), 32'h0);
    if1.CDB_rts = 4'b0000;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
